// File: rtl/little_cpu.sv
// little_cpu: multi-cycle, non-pipelined RV32I core.
// Fetch/decode/execute/(mem)/writeback sequencing with a sticky trap that halts the core.
module little_cpu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        mem_ready,
  input  logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        trap
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpFence  = 7'b0001111;

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

  state_e      state_q;
  logic [31:0] pc_q, instr_q, rs1_q, rs2_q, result_q, next_pc_q;
  logic        we_q;
  logic [1:0]  off_q;
  logic [31:0] regs [32];

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        ex_trap, ex_we, ex_load, ex_store, taken;
  logic [31:0] ex_result, ex_next_pc, ls_addr, st_data, ld_shift, ld_data;
  logic [3:0]  st_strb;

  assign opcode = instr_q[6:0];
  assign funct3 = instr_q[14:12];
  assign funct7 = instr_q[31:25];
  assign imm_i  = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_s  = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_b  = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign imm_u  = {instr_q[31:12], 12'b0};
  assign imm_j  = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21],
                   1'b0};

  function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sra;
    // Kept in its own signed variable so the arithmetic shift is not lost to unsigned context.
    sra = $signed(a) >>> b[4:0];
    case (f3)
      3'd0:    alu = alt ? a - b : a + b;
      3'd1:    alu = a << b[4:0];
      3'd2:    alu = {31'b0, $signed(a) < $signed(b)};
      3'd3:    alu = {31'b0, a < b};
      3'd4:    alu = a ^ b;
      3'd5:    alu = alt ? sra : a >> b[4:0];
      3'd6:    alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  // Execute-stage decode, ALU, branch compare, next-PC and exception detection.
  always_comb begin
    ex_trap    = 1'b0;
    ex_we      = 1'b0;
    ex_load    = 1'b0;
    ex_store   = 1'b0;
    taken      = 1'b0;
    ex_result  = '0;
    ex_next_pc = pc_q + 32'd4;
    ls_addr    = rs1_q + imm_i;
    case (opcode)
      OpLui:   begin ex_we = 1'b1; ex_result = imm_u; end
      OpAuipc: begin ex_we = 1'b1; ex_result = pc_q + imm_u; end
      OpJal: begin
        ex_we      = 1'b1;
        ex_result  = pc_q + 32'd4;
        ex_next_pc = pc_q + imm_j;
      end
      OpJalr: begin
        ex_we      = 1'b1;
        ex_result  = pc_q + 32'd4;
        ex_next_pc = (rs1_q + imm_i) & ~32'd1;
        ex_trap    = (funct3 != 3'd0);
      end
      OpBranch: begin
        case (funct3)
          3'd0:    taken = (rs1_q == rs2_q);
          3'd1:    taken = (rs1_q != rs2_q);
          3'd4:    taken = ($signed(rs1_q) < $signed(rs2_q));
          3'd5:    taken = ($signed(rs1_q) >= $signed(rs2_q));
          3'd6:    taken = (rs1_q < rs2_q);
          3'd7:    taken = (rs1_q >= rs2_q);
          default: ex_trap = 1'b1;
        endcase
        if (taken) ex_next_pc = pc_q + imm_b;
      end
      OpLoad: begin
        ex_load = 1'b1;
        ex_we   = 1'b1;
        case (funct3)
          3'd0, 3'd4: ;
          3'd1, 3'd5: ex_trap = ls_addr[0];
          3'd2:       ex_trap = |ls_addr[1:0];
          default:    ex_trap = 1'b1;
        endcase
      end
      OpStore: begin
        ls_addr  = rs1_q + imm_s;
        ex_store = 1'b1;
        case (funct3)
          3'd0:    ;
          3'd1:    ex_trap = ls_addr[0];
          3'd2:    ex_trap = |ls_addr[1:0];
          default: ex_trap = 1'b1;
        endcase
      end
      OpImm: begin
        ex_we     = 1'b1;
        ex_result = alu(funct3, (funct3 == 3'd5) && funct7[5], rs1_q, imm_i);
        if (funct3 == 3'd1 && funct7 != 7'h00) ex_trap = 1'b1;
        if (funct3 == 3'd5 && funct7 != 7'h00 && funct7 != 7'h20) ex_trap = 1'b1;
      end
      OpReg: begin
        ex_we     = 1'b1;
        ex_result = alu(funct3, funct7[5], rs1_q, rs2_q);
        if (!(funct7 == 7'h00 || (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5))))
          ex_trap = 1'b1;
      end
      OpFence: ex_trap = (funct3 != 3'd0);
      default: ex_trap = 1'b1;
    endcase
    // pc_q is always aligned, so only a redirected target can trip this.
    if (ex_next_pc[1:0] != 2'b00) ex_trap = 1'b1;
  end

  // Store lane placement and load byte/half selection with extension.
  always_comb begin
    st_data = rs2_q;
    st_strb = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        st_data = {24'b0, rs2_q[7:0]} << {ls_addr[1:0], 3'b000};
        st_strb = 4'b0001 << ls_addr[1:0];
      end
      2'b01: begin
        st_data = {16'b0, rs2_q[15:0]} << {ls_addr[1], 4'b0000};
        st_strb = ls_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
    ld_shift = mem_rdata >> {off_q, 3'b000};
    case (funct3)
      3'd0:    ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'd1:    ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'd4:    ld_data = {24'b0, ld_shift[7:0]};
      3'd5:    ld_data = {16'b0, ld_shift[15:0]};
      default: ld_data = mem_rdata;
    endcase
  end

  // Main sequencer with registered memory/fetch outputs and sticky trap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      imem_addr <= RESET_PC;
      mem_ready <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      trap      <= 1'b0;
    end else begin
      case (state_q)
        StFetch: state_q <= StDecode;
        StDecode: begin
          instr_q <= imem_data;
          rs1_q   <= (imem_data[19:15] == 5'd0) ? '0 : regs[imem_data[19:15]];
          rs2_q   <= (imem_data[24:20] == 5'd0) ? '0 : regs[imem_data[24:20]];
          state_q <= StExec;
        end
        StExec: begin
          if (ex_trap) begin
            trap    <= 1'b1;
            state_q <= StHalt;
          end else begin
            result_q  <= ex_result;
            we_q      <= ex_we;
            next_pc_q <= ex_next_pc;
            if (ex_load || ex_store) begin
              mem_ready <= 1'b1;
              mem_addr  <= {ls_addr[31:2], 2'b00};
              mem_wdata <= ex_store ? st_data : '0;
              mem_wstrb <= ex_store ? st_strb : 4'b0000;
              off_q     <= ls_addr[1:0];
              state_q   <= StMem;
            end else begin
              state_q <= StWb;
            end
          end
        end
        StMem: begin
          if (mem_valid) begin
            mem_ready <= 1'b0;
            result_q  <= ld_data;
            state_q   <= StWb;
          end
        end
        StWb: begin
          pc_q      <= next_pc_q;
          imem_addr <= next_pc_q;
          state_q   <= StFetch;
        end
        default: state_q <= StHalt;
      endcase
    end
  end

  // Register file write port; x0 is never written and reads as zero at decode.
  always_ff @(posedge clk) begin
    if (reset && state_q == StWb && we_q && instr_q[11:7] != 5'd0) begin
      regs[instr_q[11:7]] <= result_q;
    end
  end

endmodule

// File: tb/tb_little_cpu.sv
// Directed testbench for little_cpu with an instruction ROM and a latency-configurable data RAM.
module tb_little_cpu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] imem_addr, imem_data, mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready, mem_valid, trap;
  logic [3:0]  mem_wstrb;

  int total = 0;
  int bad = 0;

  logic [31:0] rom [64];
  logic [31:0] ram [256];
  int lat = 0;
  bit pend;
  int cnt;
  int req_n, wr_n, rd_n, fetch_n, rat;
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];
  logic [3:0]  wr_strb [64];
  logic [31:0] rd_log [64];
  logic [31:0] fetch_log [64];

  always #5 clk = ~clk;

  little_cpu #(.RESET_PC(32'h0)) dut (
    .clk       (clk),
    .reset     (reset),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .mem_ready (mem_ready),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .trap      (trap)
  );

  always @(posedge clk) imem_data <= rom[imem_addr[7:2]];

  always @(posedge clk) begin
    if (!reset) begin
      mem_valid <= 1'b0;
      mem_rdata <= '0;
      pend = 1'b0;
      req_n = 0;
      wr_n = 0;
      rd_n = 0;
      for (int i = 0; i < 256; i++) ram[i] = '0;
    end else if (pend) begin
      if (cnt == 0) begin
        mem_valid <= 1'b1;
        pend = 1'b0;
      end else begin
        cnt = cnt - 1;
      end
    end else begin
      mem_valid <= 1'b0;
      if (mem_ready && !mem_valid) begin
        req_n++;
        if (mem_wstrb != 4'b0000) begin
          for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) ram[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
          if (wr_n < 64) begin
            wr_addr[wr_n] = mem_addr;
            wr_data[wr_n] = mem_wdata;
            wr_strb[wr_n] = mem_wstrb;
          end
          wr_n++;
          mem_rdata <= '0;
        end else begin
          if (rd_n < 64) rd_log[rd_n] = ram[mem_addr[9:2]];
          rd_n++;
          mem_rdata <= ram[mem_addr[9:2]];
        end
        if (lat == 0) mem_valid <= 1'b1;
        else begin
          pend = 1'b1;
          cnt = lat - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      fetch_n = 0;
      rat = 0;
    end else begin
      if (trap && mem_ready) rat++;
      if (fetch_n == 0) begin
        fetch_log[0] = imem_addr;
        fetch_n = 1;
      end else if (fetch_n < 64) begin
        if (imem_addr != fetch_log[fetch_n-1]) begin
          fetch_log[fetch_n] = imem_addr;
          fetch_n++;
        end
      end
    end
  end

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 32'h0000006f;  // jal x0,0 idles in place
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_writes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (wr_n >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_imem got %h want 0", imem_addr); end
    total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got %b want 0", mem_ready); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got %h want 0", mem_addr); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_wdata got %h want 0", mem_wdata); end
    total++; if (mem_wstrb !== 4'h0) begin bad++; $display("FAIL rst_wstrb got %h want 0", mem_wstrb); end
    total++; if (trap !== 1'b0) begin bad++; $display("FAIL rst_trap got %b want 0", trap); end
  endtask

  task automatic load_loop_prog();
    clear_rom();
    rom[0] = 32'h3fc00093;
    rom[1] = 32'h0000a023;
    rom[2] = 32'h0000a103;
    rom[3] = 32'h00110113;
    rom[4] = 32'h0020a023;
    rom[5] = 32'hff5ff06f;
  endtask

  task automatic test_store_load_loop();
    logic [31:0] exp_f [7] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h8};
    bit ok;
    load_loop_prog();
    lat = 2;
    do_reset();
    wait_writes(6, 2000, ok);
    total++; if (!ok) begin bad++; $display("FAIL loop_timeout got %0d writes want 6", wr_n); end
    for (int i = 0; i < 7; i++) begin
      total++;
      if (fetch_n <= i || fetch_log[i] !== exp_f[i]) begin
        bad++; $display("FAIL loop_fetch[%0d] got %h want %h", i, fetch_log[i], exp_f[i]);
      end
    end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (wr_addr[i] !== 32'h3FC || wr_data[i] !== i || wr_strb[i] !== 4'hF) begin
        bad++; $display("FAIL loop_wr[%0d] got %h/%h/%h want 3fc/%h/f", i, wr_addr[i],
                        wr_data[i], wr_strb[i], i);
      end
    end
    total++; if (rd_n !== 5) begin bad++; $display("FAIL loop_reads got %0d want 5", rd_n); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rd_log[i] !== i) begin bad++; $display("FAIL loop_rd[%0d] got %h want %h", i, rd_log[i], i); end
    end
    total++; if (trap !== 1'b0) begin bad++; $display("FAIL loop_trap got %b want 0", trap); end
  endtask

  task automatic test_subword();
    bit ok;
    clear_rom();
    rom[0] = enc_i(32'h101, 0, 0, 1, 7'h13);
    rom[1] = enc_i(32'hAB, 0, 0, 2, 7'h13);
    rom[2] = enc_s(32'h0, 2, 1, 0);
    rom[3] = enc_s(32'h1, 2, 1, 1);
    rom[4] = enc_i(32'h0, 1, 0, 3, 7'h03);
    rom[5] = enc_i(32'h0, 1, 4, 4, 7'h03);
    rom[6] = enc_i(32'h1, 1, 5, 5, 7'h03);
    rom[7] = enc_s(32'h200, 3, 0, 2);
    rom[8] = enc_s(32'h204, 4, 0, 2);
    rom[9] = enc_s(32'h208, 5, 0, 2);
    lat = 0;
    do_reset();
    wait_writes(5, 2000, ok);
    total++; if (!ok) begin bad++; $display("FAIL sub_timeout got %0d writes want 5", wr_n); end
    total++;
    if (wr_addr[0] !== 32'h100 || wr_strb[0] !== 4'b0010 || wr_data[0][15:8] !== 8'hAB) begin
      bad++; $display("FAIL sub_sb got %h/%b/%h want 100/0010/ab", wr_addr[0], wr_strb[0],
                      wr_data[0][15:8]);
    end
    total++;
    if (wr_addr[1] !== 32'h100 || wr_strb[1] !== 4'b1100 || wr_data[1][31:16] !== 16'h00AB) begin
      bad++; $display("FAIL sub_sh got %h/%b/%h want 100/1100/00ab", wr_addr[1], wr_strb[1],
                      wr_data[1][31:16]);
    end
    total++; if (wr_data[2] !== 32'hFFFFFFAB) begin bad++; $display("FAIL sub_lb got %h want ffffffab", wr_data[2]); end
    total++; if (wr_data[3] !== 32'h000000AB) begin bad++; $display("FAIL sub_lbu got %h want 000000ab", wr_data[3]); end
    total++; if (wr_data[4] !== 32'h000000AB) begin bad++; $display("FAIL sub_lhu got %h want 000000ab", wr_data[4]); end
    total++; if (wr_addr[4] !== 32'h208) begin bad++; $display("FAIL sub_swaddr got %h want 208", wr_addr[4]); end
  endtask

  task automatic test_alu_corners();
    logic [31:0] exp_d [6] = '{32'h80000000, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 32'hFFFFFFFF};
    bit ok;
    clear_rom();
    rom[0]  = {20'h80000, 5'd1, 7'h37};
    rom[1]  = enc_i(32'hFFFFFFFF, 1, 0, 1, 7'h13);
    rom[2]  = enc_i(32'h1, 1, 0, 2, 7'h13);
    rom[3]  = enc_i(32'h41F, 2, 5, 3, 7'h13);
    rom[4]  = enc_i(32'h1, 0, 0, 4, 7'h13);
    rom[5]  = enc_r(7'h00, 3, 4, 3, 5);
    rom[6]  = enc_r(7'h00, 3, 4, 2, 6);
    rom[7]  = enc_i(32'h5, 0, 0, 0, 7'h13);
    rom[8]  = enc_r(7'h20, 4, 0, 0, 7);
    rom[9]  = enc_s(32'h300, 2, 0, 2);
    rom[10] = enc_s(32'h304, 3, 0, 2);
    rom[11] = enc_s(32'h308, 5, 0, 2);
    rom[12] = enc_s(32'h30C, 6, 0, 2);
    rom[13] = enc_s(32'h310, 0, 0, 2);
    rom[14] = enc_s(32'h314, 7, 0, 2);
    lat = 1;
    do_reset();
    wait_writes(6, 3000, ok);
    total++; if (!ok) begin bad++; $display("FAIL alu_timeout got %0d writes want 6", wr_n); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (wr_data[i] !== exp_d[i] || wr_addr[i] !== 32'h300 + 4 * i) begin
        bad++; $display("FAIL alu_val[%0d] got %h@%h want %h@%h", i, wr_data[i], wr_addr[i],
                        exp_d[i], 32'h300 + 4 * i);
      end
    end
  endtask

  task automatic test_trap_illegal();
    bit seen;
    clear_rom();
    rom[0] = 32'h00000000;
    lat = 0;
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (trap === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    total++; if (!seen) begin bad++; $display("FAIL ill_trap got %b want 1 within 4", trap); end
    repeat (20) @(posedge clk);
    #1;
    total++; if (rat !== 0) begin bad++; $display("FAIL ill_ready got %0d cycles want 0", rat); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL ill_imem got %h want 0", imem_addr); end
    total++; if (req_n !== 0) begin bad++; $display("FAIL ill_req got %0d want 0", req_n); end
    clear_rom();
    rom[0] = enc_i(32'h1, 0, 0, 1, 7'h13);
    rom[1] = 32'h00000073;
    rom[2] = enc_s(32'h200, 1, 0, 2);
    do_reset();
    repeat (40) @(posedge clk);
    #1;
    total++; if (trap !== 1'b1) begin bad++; $display("FAIL ecall_trap got %b want 1", trap); end
    total++; if (imem_addr !== 32'h4) begin bad++; $display("FAIL ecall_imem got %h want 4", imem_addr); end
    total++; if (req_n !== 0) begin bad++; $display("FAIL ecall_req got %0d want 0", req_n); end
  endtask

  task automatic test_trap_misaligned();
    clear_rom();
    rom[0] = enc_i(32'h102, 0, 0, 1, 7'h13);
    rom[1] = enc_i(32'h0, 1, 2, 2, 7'h03);
    rom[2] = enc_s(32'h200, 1, 0, 2);
    lat = 0;
    do_reset();
    repeat (40) @(posedge clk);
    #1;
    total++; if (trap !== 1'b1) begin bad++; $display("FAIL lw_mis_trap got %b want 1", trap); end
    total++; if (req_n !== 0) begin bad++; $display("FAIL lw_mis_req got %0d want 0", req_n); end
    total++; if (imem_addr !== 32'h4) begin bad++; $display("FAIL lw_mis_imem got %h want 4", imem_addr); end
    clear_rom();
    rom[0] = enc_i(32'h101, 0, 0, 1, 7'h13);
    rom[1] = enc_s(32'h0, 0, 1, 1);
    do_reset();
    repeat (40) @(posedge clk);
    #1;
    total++; if (trap !== 1'b1 || req_n !== 0) begin
      bad++; $display("FAIL sh_mis got trap=%b req=%0d want 1/0", trap, req_n);
    end
  endtask

  task automatic test_reset_mid_access();
    bit ok;
    load_loop_prog();
    lat = 20;
    do_reset();
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mem_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    total++; if (!ok) begin bad++; $display("FAIL mid_noreq got %b want 1", mem_ready); end
    reset = 1'b0;
    @(posedge clk);
    #1;
    total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL mid_ready got %b want 0", mem_ready); end
    total++; if (trap !== 1'b0) begin bad++; $display("FAIL mid_trap got %b want 0", trap); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL mid_imem got %h want 0", imem_addr); end
    lat = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    wait_writes(4, 2000, ok);
    total++; if (!ok) begin bad++; $display("FAIL mid_timeout got %0d writes want 4", wr_n); end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (wr_data[i] !== i || wr_addr[i] !== 32'h3FC) begin
        bad++; $display("FAIL mid_wr[%0d] got %h@%h want %h@3fc", i, wr_data[i], wr_addr[i], i);
      end
    end
  endtask

  task automatic test_branch_jalr();
    bit ok;
    clear_rom();
    rom[0]  = enc_i(32'h11, 0, 0, 1, 7'h13);
    rom[1]  = enc_i(32'h0, 1, 0, 6, 7'h67);
    rom[2]  = enc_s(32'h204, 0, 0, 2);
    rom[3]  = enc_s(32'h204, 0, 0, 2);
    rom[4]  = enc_s(32'h200, 6, 0, 2);
    rom[5]  = enc_i(32'h6, 0, 0, 2, 7'h13);
    rom[6]  = enc_b(32'h8, 2, 1, 0);
    rom[7]  = enc_s(32'h208, 2, 0, 2);
    rom[8]  = enc_b(32'h8, 2, 2, 0);
    rom[9]  = enc_s(32'h20C, 1, 0, 2);
    rom[10] = enc_s(32'h210, 1, 0, 2);
    lat = 0;
    do_reset();
    wait_writes(3, 2000, ok);
    repeat (60) @(negedge clk);
    total++; if (!ok || wr_n !== 3) begin bad++; $display("FAIL br_count got %0d want 3", wr_n); end
    total++; if (wr_addr[0] !== 32'h200 || wr_data[0] !== 32'h8) begin
      bad++; $display("FAIL jalr_link got %h@%h want 8@200", wr_data[0], wr_addr[0]);
    end
    total++; if (wr_addr[1] !== 32'h208 || wr_data[1] !== 32'h6) begin
      bad++; $display("FAIL beq_nt got %h@%h want 6@208", wr_data[1], wr_addr[1]);
    end
    total++; if (wr_addr[2] !== 32'h210 || wr_data[2] !== 32'h11) begin
      bad++; $display("FAIL beq_t got %h@%h want 11@210", wr_data[2], wr_addr[2]);
    end
    total++; if (fetch_log[2] !== 32'h10) begin bad++; $display("FAIL jalr_tgt got %h want 10", fetch_log[2]); end
    total++; if (fetch_log[7] !== 32'h28) begin bad++; $display("FAIL br_tgt got %h want 28", fetch_log[7]); end
    total++; if (trap !== 1'b0) begin bad++; $display("FAIL br_trap got %b want 0", trap); end
  endtask

  initial begin
    clear_rom();
    test_reset();
    test_store_load_loop();
    test_subword();
    test_alu_corners();
    test_trap_illegal();
    test_trap_misaligned();
    test_reset_mid_access();
    test_branch_jalr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/little_cpu.md
Name: little_cpu

Overview:
- Multi-cycle, non-pipelined RV32I integer core. Harvard interfaces: a synchronous read-only instruction port and a request/response data-memory port.
- Sits at the top of the CPU subsystem, driving instruction ROM and data RAM directly.
- Raises a sticky trap and halts on any exception.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first instruction fetched after reset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- imem_addr  out  32  byte address of the instruction being fetched. Always word aligned.
- imem_data  in  32  instruction word. Registered by the ROM: valid one cycle after imem_addr is presented.
- mem_ready  out  1  data-access request. Held high until the response arrives.
- mem_valid  in  1  one-cycle response pulse from memory; mem_rdata is valid in the same cycle.
- mem_addr  out  32  word-aligned data address, with bits [1:0] = 0.
- mem_wdata  out  32  store data, shifted into the addressed byte lanes.
- mem_wstrb  out  4  byte-lane write enables. 0000 means read.
- mem_rdata  in  32  load data word.
- trap  out  1  sticky exception flag.

Behaviour:
- Reset (reset==0 at a clock edge):
  - PC=RESET_PC and imem_addr=RESET_PC.
  - mem_ready=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, trap=0.
  - State goes to FETCH.
  - The register file is not cleared. x0 always reads 0 and writes to x0 are discarded.
  - Reset has priority in any state and aborts an outstanding memory request; mem_ready drops at that same edge.
- States: FETCH -> DECODE -> EXECUTE -> (MEM) -> WRITEBACK -> FETCH. Any state can go to HALT.
  - FETCH: imem_addr=PC for one cycle.
  - DECODE: latch imem_data as the instruction; read rs1 and rs2.
  - EXECUTE: ALU operation, branch compare, and next-PC/address computation.
  - MEM: issue the data request and wait for the response.
  - WRITEBACK: write rd and update PC.
- Timing: non-memory instructions take 4 cycles. Loads and stores add 2 or more cycles, depending on the memory response.
- ISA coverage: full RV32I.
  - LUI, AUIPC, JAL, JALR (target with bit0 cleared), all branches.
  - Loads: LB/LH/LW/LBU/LHU. Stores: SB/SH/SW.
  - All OP-IMM and OP instructions. Shift amount uses the low 5 bits.
  - FENCE executes as a NOP.
- Arithmetic: 32-bit, wrapping with no overflow detection. SLT/SLTI are signed; SLTU/SLTIU are unsigned. SRA/SRAI sign-fill.
- Data handshake:
  - In MEM, assert mem_ready=1 with mem_addr, mem_wdata and mem_wstrb stable.
  - Memory samples the request on an edge where mem_ready=1 and mem_valid=0.
  - On the edge where mem_valid=1 is seen: capture mem_rdata and deassert mem_ready at that same edge. Memory must never see a second request for one instruction.
- Store lanes:
  - SW: wstrb=1111.
  - SH: wstrb=0011 or 1100, selected by addr[1]; data placed in the matching half.
  - SB: wstrb=0001 shifted left by addr[1:0]; data byte in the matching lane.
- Loads: wstrb=0000. Select the byte or half of mem_rdata using addr[1:0], then sign- or zero-extend.
- Trap conditions: illegal or unsupported opcode/funct, ECALL, EBREAK, any other SYSTEM instruction, misaligned LH/LHU/SH (addr[0]=1), misaligned LW/SW (addr[1:0]!=0), and a JAL/JALR/taken-branch target with bits [1:0]!=0.
- On trap:
  - trap=1 from the next edge and stays high until reset.
  - The faulting instruction does not write rd or memory.
  - The core enters HALT, issues no further requests, and holds imem_addr constant.
- Outputs not otherwise specified hold their last value.

Test Plan:
- Store/load loop: ROM = 3fc00093, 0000a023, 0000a103, 00110113, 0020a023, ff5ff06f. Release reset.
  - imem_addr sequence: 0, 4, 8, C, 10, 14, 8, ...
  - Memory writes at 0x3FC: 0x0, 0x1, 0x2, ..., each with wstrb=1111, interleaved with reads returning the prior value.
  - trap stays 0 and each access completes exactly once.
- Sub-word access: SB of 0xAB at 0x101 -> mem_addr=0x100, wstrb=0010, wdata[15:8]=AB. LB from 0x101 -> 0xFFFFFFAB; LBU -> 0x000000AB.
- ALU corners: ADDI of 0x7FFFFFFF+1 -> 0x80000000. SRAI of 0x80000000 by 31 -> 0xFFFFFFFF. SLTU 1 < 0xFFFFFFFF -> 1; SLT of the same operands -> 0. ADDI to x0 leaves x0=0.
- Traps:
  - ROM word 0x00000000 -> trap=1 within 4 cycles; no mem_ready afterward; imem_addr frozen.
  - LW from 0x102 -> trap with no memory request.
- Reset mid-access: assert reset while mem_ready=1 -> next edge gives mem_ready=0, trap=0, imem_addr=RESET_PC, and the program restarts correctly.
- Branch/JALR: BEQ taken and not taken. JALR to 0x11 jumps to 0x10 and writes rd=PC+4.
